up_counter: RTL and testbench
=============================

UP_COUNTER -- requirements
Module: up_counter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all other logic is synchronous to the rising edge of clk.
REQ-002 Parameter N, default 4, is the counter width in bits (legal range 1..32).
REQ-003 Parameter PRESCALE, default 1, is the number of enabled clk cycles per count step (legal range 1..65535).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 en  input  1  count enable; tie to 1 for free-running operation.
REQ-007 clr  input  1  synchronous clear.
REQ-008 load  input  1  synchronous parallel load.
REQ-009 d  input  N  load value.
REQ-010 q  output  N  current count, registered.
REQ-011 tc  output  1  terminal count, combinational: 1 when q equals all ones.
REQ-012 co  output  1  carry-out, combinational: tc AND step, i.e. 1 in the cycle whose edge wraps q to 0.

Function
REQ-013 The internal step SHALL be en AND (prescaler at PRESCALE-1); with PRESCALE=1, step equals en.
REQ-014 On each rising edge, priority SHALL be clr > load > step > hold.
REQ-015 clr: q <= 0 and prescaler <= 0, regardless of en.
REQ-016 load: q <= d and prescaler <= 0, regardless of en.
REQ-017 step: q <= q+1 modulo 2^N; from all ones, q wraps to 0 with no saturation.
REQ-018 en=1 without step: the prescaler increments and q holds; en=0: both prescaler and q hold.
REQ-019 Simultaneous clr and load: clr wins and d is ignored.
REQ-020 Simultaneous load and step: load wins and the increment is discarded.
REQ-021 With en=1 and PRESCALE=P, q SHALL advance once every P edges, which gives a period of P*2^N edges.
REQ-022 tc and co SHALL have no registered latency; q changes one edge after the controlling input is sampled.

Reset
REQ-023 rst=1 SHALL immediately force q=0 and prescaler=0, independent of clk, including mid-count.
REQ-024 While rst=1, tc=0 and co=0 for N≥1, and all synchronous inputs are ignored.
REQ-025 After rst is released, the first count step SHALL occur at the first edge where step=1; no extra cycle is inserted.

Structure
REQ-026 Shared package upcounter_pkg SHALL hold the default constants UPCOUNTER_N_DEF=4 and UPCOUNTER_PRESCALE_DEF=1, plus a helper function for the prescaler width, clog2(PRESCALE) with a minimum of 1.
REQ-027 One sub-module, upcounter_prescaler, SHALL contain the modulo-PRESCALE tick generator with inputs clk, rst, en, sync_clr and output tick.
REQ-028 When PRESCALE=1, upcounter_prescaler SHALL degenerate to tick=en with no flops.
REQ-029 up_counter SHALL contain the count register, the priority mux, and the tc/co logic.

Verification
REQ-030 Reset: N=4, assert rst with clk running -> q=0 immediately and tc=0; release rst with en=1 -> q counts 1, 2, 3 on successive edges.
REQ-031 Free-run wrap: N=4, PRESCALE=1, en=1 for 20 edges from 0 -> q goes 0..15 then 0..3; tc=1 only when q=15; co pulses exactly once.
REQ-032 Load/clear priority: q=5, load=1, d=4'hA -> q=A next edge; clr=1, load=1, d=4'h3 -> q=0 next edge.
REQ-033 Enable hold: en=0 for 10 edges at q=7 -> q stays 7; en=1 -> q=8 on the next edge.
REQ-034 Prescale: PRESCALE=3, en=1 from reset -> q increments on edges 3, 6, 9, ...; load mid-prescale restarts the 3-edge spacing.
REQ-035 Async reset mid-count: q=9, pulse rst between edges -> q=0 before the next edge; normal counting resumes after release.

Source files
------------

// File: rtl/upcounter_pkg.sv
// ============================================================================
// Module : upcounter_pkg
// Brief  : Shared defaults and prescaler-width helper for the up_counter slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package upcounter_pkg;

  localparam int unsigned UPCOUNTER_N_DEF        = 4;
  localparam int unsigned UPCOUNTER_PRESCALE_DEF = 1;

  // Prescaler width: clog2(prescale), never less than one bit.
  function automatic int unsigned upcounter_presc_w(input int unsigned prescale);
    return (prescale <= 1) ? 1 : $clog2(prescale);
  endfunction

endpackage : upcounter_pkg

`default_nettype wire

// File: rtl/upcounter_prescaler.sv
// ============================================================================
// Module : upcounter_prescaler
// Brief  : Modulo-PRESCALE tick generator; collapses to tick = en when PRESCALE = 1.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module upcounter_prescaler
  import upcounter_pkg::*;
#(
  parameter int unsigned PRESCALE = UPCOUNTER_PRESCALE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  localparam int unsigned CNT_W = upcounter_presc_w(PRESCALE);

  generate
    if (PRESCALE <= 1) begin : g_bypass
      logic unused_ok;
      assign unused_ok = ^{clk, rst, sync_clr};
      assign tick      = en;
    end else begin : g_count
      localparam logic [CNT_W-1:0] c_last = CNT_W'(PRESCALE - 1);

      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             at_last;

      assign at_last = (cnt_q == c_last);
      assign tick    = en & at_last;

      always_comb begin
        cnt_d = cnt_q;
        if (sync_clr) begin
          cnt_d = '0;
        end else if (en) begin
          cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

endmodule : upcounter_prescaler

`default_nettype wire

// File: rtl/up_counter.sv
// ============================================================================
// Module : up_counter
// Brief  : N-bit prescaled up-counter with clear/load priority and tc/co flags.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module up_counter
  import upcounter_pkg::*;
#(
  parameter int unsigned N        = UPCOUNTER_N_DEF,
  parameter int unsigned PRESCALE = UPCOUNTER_PRESCALE_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic         tc,
  output logic         co
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;
  logic         step;
  logic         presc_clr;

  // Any clear or load restarts the prescale spacing.
  assign presc_clr = clr | load;

  upcounter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync_clr (presc_clr),
    .tick     (step)
  );

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d = d;
    end else if (step) begin
      q_d = q_q + N'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign tc = &q_q;
  assign co = tc & step;

endmodule : up_counter

`default_nettype wire

// File: tb/tb_up_counter.sv
// ============================================================================
// Module : tb_up_counter
// Brief  : Scoreboard bench for up_counter with PRESCALE=1 and PRESCALE=3 instances.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_up_counter;

  typedef struct {
    int         sel;
    logic [3:0] q;
    logic       tc;
    logic       co;
    string      tag;
  } exp_t;

  logic       clk;
  logic       rst_s  [2];
  logic       en_s   [2];
  logic       clr_s  [2];
  logic       load_s [2];
  logic [3:0] d_s    [2];
  logic [3:0] q_s    [2];
  logic       tc_s   [2];
  logic       co_s   [2];

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  up_counter #(.N(4), .PRESCALE(1)) u_dut0 (
    .clk (clk), .rst (rst_s[0]), .en (en_s[0]), .clr (clr_s[0]),
    .load (load_s[0]), .d (d_s[0]), .q (q_s[0]), .tc (tc_s[0]), .co (co_s[0])
  );

  up_counter #(.N(4), .PRESCALE(3)) u_dut1 (
    .clk (clk), .rst (rst_s[1]), .en (en_s[1]), .clr (clr_s[1]),
    .load (load_s[1]), .d (d_s[1]), .q (q_s[1]), .tc (tc_s[1]), .co (co_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge and queue the state expected
  // in this half-cycle (q from the previous rising edge, tc/co from q and inputs).
  task automatic drv(input int sel, input logic r, input logic e, input logic c,
                     input logic l, input logic [3:0] dv, input logic [3:0] eq,
                     input logic etc, input logic eco, input string tag,
                     input bit pulse);
    exp_t x;
    @(negedge clk);
    rst_s[sel]  = r;
    en_s[sel]   = e;
    clr_s[sel]  = c;
    load_s[sel] = l;
    d_s[sel]    = dv;
    x.sel = sel; x.q = eq; x.tc = etc; x.co = eco; x.tag = tag;
    sb.push_back(x);
    if (pulse) begin
      #3;
      rst_s[sel] = 1'b0;
    end
  endtask

  // Monitor: the counter presents its state every cycle; compare 1 time unit
  // after the falling edge, once the driver has applied that cycle's inputs.
  initial begin : p_monitor
    exp_t x;
    logic [3:0] aq;
    logic       atc;
    logic       aco;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
        x   = sb.pop_front();
        aq  = q_s[x.sel];
        atc = tc_s[x.sel];
        aco = co_s[x.sel];
        checks++;
        if (aq !== x.q) begin
          errors++;
          $display("FAIL %s dut%0d q: got %h want %h", x.tag, x.sel, aq, x.q);
        end
        checks++;
        if (atc !== x.tc) begin
          errors++;
          $display("FAIL %s dut%0d tc: got %b want %b", x.tag, x.sel, atc, x.tc);
        end
        checks++;
        if (aco !== x.co) begin
          errors++;
          $display("FAIL %s dut%0d co: got %b want %b", x.tag, x.sel, aco, x.co);
        end
      end
    end
  end

  initial begin : p_stim
    for (int s = 0; s < 2; s++) begin
      rst_s[s] = 1'b1; en_s[s] = 1'b0; clr_s[s] = 1'b0;
      load_s[s] = 1'b0; d_s[s] = 4'h0;
    end

    // ---------------- PRESCALE = 1 ----------------
    // Reset holds q at 0 and ignores a pending load.
    drv(0, 1, 1, 0, 1, 4'hF, 4'h0, 0, 0, "rst_hold", 0);
    drv(0, 1, 1, 0, 0, 4'h0, 4'h0, 0, 0, "rst_ignore_load", 0);
    // Release and free-run: 0..15 then 0..3, single co at 15.
    for (int i = 0; i < 20; i++) begin
      drv(0, 0, 1, 0, 0, 4'h0, 4'(i), (i % 16 == 15), (i % 16 == 15), "freerun", 0);
    end
    drv(0, 0, 1, 0, 0, 4'h0, 4'h4, 0, 0, "to5", 0);
    // Load, then clr beats load.
    drv(0, 0, 1, 0, 1, 4'hA, 4'h5, 0, 0, "load_A", 0);
    drv(0, 0, 1, 1, 1, 4'h3, 4'hA, 0, 0, "clr_over_load", 0);
    drv(0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, "after_clr", 0);
    // Enable hold at 7.
    drv(0, 0, 0, 0, 1, 4'h7, 4'h0, 0, 0, "load_7", 0);
    for (int i = 0; i < 10; i++) begin
      drv(0, 0, 0, 0, 0, 4'h0, 4'h7, 0, 0, "en_hold", 0);
    end
    drv(0, 0, 1, 0, 0, 4'h0, 4'h7, 0, 0, "en_resume", 0);
    drv(0, 0, 0, 0, 1, 4'hF, 4'h8, 0, 0, "q8_load_F", 0);
    // At all ones with en=1 and load=1: co still fires, load wins.
    drv(0, 0, 1, 0, 1, 4'h2, 4'hF, 1, 1, "load_over_step", 0);
    drv(0, 0, 0, 0, 1, 4'h9, 4'h2, 0, 0, "load_wins", 0);
    drv(0, 0, 0, 0, 0, 4'h0, 4'h9, 0, 0, "at9", 0);
    // Async reset pulse between edges.
    drv(0, 1, 1, 0, 0, 4'h0, 4'h0, 0, 0, "async_rst", 1);
    drv(0, 0, 1, 0, 0, 4'h0, 4'h1, 0, 0, "resume1", 0);
    drv(0, 0, 0, 0, 0, 4'h0, 4'h2, 0, 0, "resume2", 0);

    // ---------------- PRESCALE = 3 ----------------
    drv(1, 1, 1, 0, 0, 4'h0, 4'h0, 0, 0, "p3_rst", 0);
    for (int k = 0; k < 10; k++) begin
      drv(1, 0, 1, 0, 0, 4'h0, 4'(k / 3), 0, 0, "p3_run", 0);
    end
    // Load mid-prescale restarts the 3-edge spacing.
    drv(1, 0, 1, 0, 1, 4'h8, 4'h3, 0, 0, "p3_load8", 0);
    drv(1, 0, 1, 0, 0, 4'h0, 4'h8, 0, 0, "p3_sp0", 0);
    drv(1, 0, 1, 0, 0, 4'h0, 4'h8, 0, 0, "p3_sp1", 0);
    drv(1, 0, 1, 0, 0, 4'h0, 4'h8, 0, 0, "p3_sp2", 0);
    drv(1, 0, 1, 0, 1, 4'hF, 4'h9, 0, 0, "p3_loadF", 0);
    // tc holds for three cycles, co only on the stepping one.
    drv(1, 0, 1, 0, 0, 4'h0, 4'hF, 1, 0, "p3_tc0", 0);
    drv(1, 0, 1, 0, 0, 4'h0, 4'hF, 1, 0, "p3_tc1", 0);
    drv(1, 0, 1, 0, 0, 4'h0, 4'hF, 1, 1, "p3_co", 0);
    drv(1, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, "p3_wrap", 0);

    stim_done = 1'b1;
  end

  initial begin : p_end
    wait (stim_done);
    for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : p_watchdog
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule : tb_up_counter

`default_nettype wire
